lstm_seq_ctrl: RTL and testbench
================================

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameters: LAYERS, default 3, stack depth; WIDTH, default 16, sample width; LEN_W, default 8, sequence-length counter width; DEPTH, default 8, result FIFO depth (power of 2, >= 2).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to run one sequence; honoured only in IDLE.
REQ-005 cfg_seq_len  in  LEN_W  number of timesteps; sampled on an accepted start.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse at end of sequence.
REQ-008 in_data/in_valid/in_ready  in/in/out  WIDTH/1/1  input sample stream (valid/ready).
REQ-009 stk_ready  in  1  ready from the LSTM layer stack.
REQ-010 stk_x_in/stk_x_in_valid  out  WIDTH/1  sample issued to the stack.
REQ-011 stk_h_in, stk_C_in  out  LAYERS x WIDTH  state-init values, driven all-zero.
REQ-012 stk_h_in_valid, stk_C_in_valid  out  LAYERS  per-layer state-load strobes.
REQ-013 stk_y_out/stk_valid  in  WIDTH/1  result from the last layer; no backpressure.
REQ-014 out_data/out_valid/out_ready/out_last  out/out/in/out  WIDTH/1/1/1  result stream; out_last marks the final timestep.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 FSM states are IDLE, INIT, RUN, DRAIN and DONE.
REQ-017 IDLE -> INIT on start with cfg_seq_len != 0; IDLE -> DONE on start with cfg_seq_len == 0.
REQ-018 INIT: all stk_h_in_valid/stk_C_in_valid bits are high for exactly one cycle, the first cycle that stk_ready is high; the FSM then enters RUN.
REQ-019 Issue condition: state == RUN, in_valid, stk_ready, issued < len, and (inflight + fifo_count) < DEPTH.
REQ-020 When the issue condition holds, stk_x_in_valid = 1, stk_x_in = in_data and in_ready = 1 in the same cycle (combinational pass-through, zero latency).
REQ-021 in_ready is low whenever the issue condition, ignoring in_valid, is false.
REQ-022 Each issue increments the issued counter and the inflight counter.
REQ-023 stk_valid decrements inflight and writes stk_y_out into the FIFO.
REQ-024 An issue and an stk_valid in the same cycle leave inflight unchanged.
REQ-025 RUN -> DRAIN in the cycle after issued reaches len.
REQ-026 DRAIN -> DONE when inflight == 0, fifo_count == 0 and received == len.
REQ-027 DONE lasts one cycle with done = 1, then returns to IDLE.
REQ-028 The FIFO is first-word-fall-through: out_valid = (fifo_count != 0), out_data = head entry; the head pops when out_valid && out_ready.
REQ-029 A push and a pop in the same cycle are both performed; a push when the FIFO is full is impossible by the credit rule of REQ-019.
REQ-030 out_last = 1 on the entry whose received index equals len-1; the received counter increments on each pop.
REQ-031 err sets on stk_valid with inflight == 0, or stk_valid with the FIFO full; the offending result is dropped and err stays set until reset.
REQ-032 start outside IDLE is ignored; cfg_seq_len changes after acceptance have no effect.
REQ-033 Counters issued, inflight and received are LEN_W+1 bits wide; inflight never exceeds DEPTH.

Reset
REQ-034 On rst: FSM goes to IDLE, all counters are 0, FIFO pointers are 0, err = 0.
REQ-035 During reset, busy, done, in_ready, out_valid, out_last, stk_x_in_valid, all state-load strobes and all data outputs are 0.
REQ-036 Reset mid-sequence discards in-flight and buffered results; stk_valid pulses arriving after reset is released are counted as errors per REQ-031.

Structure
REQ-037 Package lstm_pkg holds the FSM state enum and the default WIDTH/LAYERS constants shared with the layer stack.
REQ-038 The result buffer is one sub-module, lstm_seq_fifo (parameters WIDTH, DEPTH; FWFT; exposes count).

Verification
REQ-039 Stack with 3-cycle latency, seq_len = 4, inputs 1..4, out_ready = 1: one init strobe cycle, then 4 issues; outputs in order with out_last on the 4th; done one cycle after the last pop.
REQ-040 DEPTH = 4, out_ready = 0, seq_len = 10: issuing stalls after 4 issues; in_ready stays 0; releasing out_ready resumes issue; 10 results arrive in order with no err.
REQ-041 stk_ready toggled 1/0 each cycle: no stk_x_in_valid while stk_ready = 0; in_ready follows it combinationally.
REQ-042 start with seq_len = 0: busy for exactly one cycle (DONE), done pulses, no strobes and no issues.
REQ-043 rst asserted after 2 of 5 issues: all outputs are 0 asynchronously; a late stk_valid after release sets err.
REQ-044 start pulsed during RUN with a different cfg_seq_len: ignored; the original length completes.

Source files
------------

// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lstm_pkg
// Description : Shared constants and sequencer FSM state type for the LSTM
//               layer stack and its sequence controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_pkg;

    localparam int c_default_width  = 16;
    localparam int c_default_layers = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/lstm_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_fifo
// Description : First-word-fall-through result buffer with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && (r_count != '0);
    assign count     = r_count;
    // Data is forced to zero when empty so nothing stale leaks out of reset.
    assign pop_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_do_push} - {{c_ptr_w{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_ctrl
// Description : Sequences one LSTM run: state init, credit-limited sample
//               issue to the layer stack, and buffered in-order result output.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int LAYERS = c_default_layers,
    parameter int WIDTH  = c_default_width,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_seq_len,
    output logic                    busy,
    output logic                    done,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    stk_ready,
    output logic [WIDTH-1:0]        stk_x_in,
    output logic                    stk_x_in_valid,
    output logic [LAYERS*WIDTH-1:0] stk_h_in,
    output logic [LAYERS*WIDTH-1:0] stk_C_in,
    output logic [LAYERS-1:0]       stk_h_in_valid,
    output logic [LAYERS-1:0]       stk_C_in_valid,
    input  logic [WIDTH-1:0]        stk_y_out,
    input  logic                    stk_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    err
);

    localparam int c_cnt_w  = LEN_W + 1;
    localparam int c_fcnt_w = $clog2(DEPTH) + 1;
    localparam int c_sum_w  = ((c_cnt_w > c_fcnt_w) ? c_cnt_w : c_fcnt_w) + 1;

    seq_state_t          r_state;
    logic [LEN_W-1:0]    r_len;
    logic [c_cnt_w-1:0]  r_issued;
    logic [c_cnt_w-1:0]  r_inflight;
    logic [c_cnt_w-1:0]  r_received;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [c_fcnt_w-1:0] w_fifo_count;
    logic                w_fifo_full;
    logic [c_cnt_w-1:0]  w_len_ext;
    logic [c_sum_w-1:0]  w_fill;
    logic                w_can_issue;
    logic                w_issue;
    logic                w_accept;
    logic                w_pop;
    logic                w_init_load;

    assign w_len_ext   = {1'b0, r_len};
    // Credit covers both results still in the stack and results already buffered.
    assign w_fill      = c_sum_w'(r_inflight) + c_sum_w'(w_fifo_count);
    assign w_can_issue = (r_state == ST_RUN) && stk_ready && (r_issued < w_len_ext)
                         && (w_fill < c_sum_w'(DEPTH));
    assign w_issue     = w_can_issue && in_valid;
    assign w_accept    = stk_valid && (r_inflight != '0) && !w_fifo_full;
    assign w_pop       = out_valid && out_ready;
    assign w_init_load = (r_state == ST_INIT) && stk_ready;

    assign in_ready       = w_can_issue;
    assign stk_x_in_valid = w_issue;
    assign stk_x_in       = w_issue ? in_data : '0;
    assign stk_h_in       = '0;
    assign stk_C_in       = '0;
    assign stk_h_in_valid = {LAYERS{w_init_load}};
    assign stk_C_in_valid = {LAYERS{w_init_load}};
    assign out_valid      = (w_fifo_count != '0);
    assign out_last       = out_valid && (r_received == w_len_ext - c_cnt_w'(1));
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

    lstm_seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (stk_y_out),
        .pop       (w_pop),
        .pop_data  (out_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= '0;
            r_received <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stk_valid && !w_accept) r_err <= 1'b1;
            if (w_issue) r_issued <= r_issued + c_cnt_w'(1);
            if (w_pop)   r_received <= r_received + c_cnt_w'(1);
            case ({w_issue, w_accept})
                2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                default: r_inflight <= r_inflight;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len      <= cfg_seq_len;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_busy     <= 1'b1;
                        if (cfg_seq_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    if (stk_ready) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_issue && (r_issued + c_cnt_w'(1) == w_len_ext)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((r_inflight == '0) && (w_fifo_count == '0) && (r_received == w_len_ext)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lstm_seq_ctrl
// Description : Scoreboard bench for lstm_seq_ctrl with a latency-modelled
//               layer stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_ctrl;

    localparam int LAYERS = 3;
    localparam int WIDTH  = 16;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        cfg_seq_len = '0;
    logic                    busy, done, in_ready, stk_x_in_valid;
    logic [WIDTH-1:0]        in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    stk_ready = 1'b0;
    logic [WIDTH-1:0]        stk_x_in;
    logic [LAYERS*WIDTH-1:0] stk_h_in, stk_C_in;
    logic [LAYERS-1:0]       stk_h_in_valid, stk_C_in_valid;
    logic [WIDTH-1:0]        stk_y_out = '0;
    logic                    stk_valid = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid, out_last, err;
    logic                    out_ready = 1'b0;

    always #5 clk = ~clk;

    lstm_seq_ctrl #(
        .LAYERS (LAYERS),
        .WIDTH  (WIDTH),
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_seq_len    (cfg_seq_len),
        .busy           (busy),
        .done           (done),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .stk_ready      (stk_ready),
        .stk_x_in       (stk_x_in),
        .stk_x_in_valid (stk_x_in_valid),
        .stk_h_in       (stk_h_in),
        .stk_C_in       (stk_C_in),
        .stk_h_in_valid (stk_h_in_valid),
        .stk_C_in_valid (stk_C_in_valid),
        .stk_y_out      (stk_y_out),
        .stk_valid      (stk_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .err            (err)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cyc    = 0;
    int stk_lat = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;
    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } stk_t;

    exp_t exp_q[$];
    stk_t stk_q[$];

    function automatic logic [WIDTH-1:0] layer_fn(input logic [WIDTH-1:0] x);
        return x * 16'd3 + 16'h5a5a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Layer stack model: fixed latency, in order, never back-pressures results.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (stk_q.size() > 0 && stk_q[0].due <= cyc) begin
            stk_valid = 1'b1;
            stk_y_out = stk_q[0].data;
            void'(stk_q.pop_front());
        end else begin
            stk_valid = 1'b0;
            stk_y_out = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst && stk_x_in_valid) stk_q.push_back('{layer_fn(stk_x_in), cyc + stk_lat});
    end

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got data %0h, nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_last", 32'(out_last), 32'(e.last));
                pops++;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_x_valid"}, 32'(stk_x_in_valid), 0);
        chk({tag, "_h_valid"}, 32'(stk_h_in_valid), 0);
        chk({tag, "_c_valid"}, 32'(stk_C_in_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_x_data"}, 32'(stk_x_in), 0);
        chk({tag, "_h_or_c"}, 32'(|{stk_h_in, stk_C_in}), 0);
    endtask

    // stk_mode: 0 always ready, 1 toggling, 2 random. out_mode: 0 ready,
    // 1 held off for 40 cycles, 2 random. poke: loop cycle of a stray start.
    task automatic run_seq(input int len, input int stk_mode, input int out_mode,
                           input int vmode, input int lat, input int poke);
        logic [WIDTH-1:0] samples[$];
        int  idx, strobes, busy_cyc, pops0;
        bit  seen_done;
        stk_lat = lat;
        for (int i = 0; i < len; i++) samples.push_back(WIDTH'($urandom));
        idx = 0; strobes = 0; busy_cyc = 0; seen_done = 0; pops0 = pops;
        @(posedge clk); #1;
        start = 1'b1; cfg_seq_len = LEN_W'(len); in_valid = 1'b0;
        for (int n = 0; n < 3000 && !seen_done; n++) begin
            @(posedge clk); #1;
            start       = (n == poke);
            cfg_seq_len = LEN_W'($urandom);
            in_valid    = (idx < len) && (vmode == 0 || $urandom_range(0, 3) != 0);
            in_data     = (idx < len) ? samples[idx] : WIDTH'($urandom);
            stk_ready   = (stk_mode == 0) ? 1'b1 : (stk_mode == 1) ? n[0] : 1'($urandom_range(0, 1));
            out_ready   = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? (n >= 40) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back('{layer_fn(samples[idx]), (idx == len - 1)});
                idx++;
            end
            chk("x_valid_is_handshake", 32'(stk_x_in_valid), 32'(in_valid && in_ready));
            if (stk_x_in_valid) chk("x_passthrough", 32'(stk_x_in), 32'(in_data));
            chk("strobe_pair", 32'(stk_h_in_valid), 32'(stk_C_in_valid));
            if (stk_h_in_valid == '1) strobes++;
            if (!stk_ready) begin
                chk("x_valid_when_stalled", 32'(stk_x_in_valid), 0);
                chk("in_ready_when_stalled", 32'(in_ready), 0);
            end
            if (out_mode == 1 && n == 30) begin
                chk("credit_stall_issues", 32'(idx), DEPTH);
                chk("credit_stall_in_ready", 32'(in_ready), 0);
            end
            if (busy) busy_cyc++;
            if (done) seen_done = 1;
        end
        chk("done_seen", 32'(seen_done), 1);
        chk("issue_count", 32'(idx), 32'(len));
        chk("init_strobe_cycles", 32'(strobes), (len == 0) ? 0 : 1);
        if (len == 0) chk("busy_cycles_len0", 32'(busy_cyc), 1);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        chk("results_popped", 32'(pops - pops0), 32'(len));
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("err_clear", 32'(err), 0);
    endtask

    task automatic reset_mid_run();
        int idx;
        stk_lat = 8;
        idx = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_seq_len = LEN_W'(5); in_valid = 1'b0;
        stk_ready = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 200 && idx < 2; n++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_data = WIDTH'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        chk("pre_reset_issues", 32'(idx), 2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk); #2;
        rst = 1'b0; in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("late_result_err", 32'(err), 1);
        chk("err_not_busy", 32'(busy), 0);
        #1 rst = 1'b1;
        #3;
        chk("err_cleared_by_reset", 32'(err), 0);
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b1;
        stk_ready = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        in_data   = 16'hbeef;
        cfg_seq_len = 8'd3;
        #12;
        check_all_zero("reset");
        chk("reset_err", 32'(err), 0);
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;

        run_seq(4, 0, 0, 0, 3, -1);
        run_seq(10, 0, 1, 0, 3, -1);
        run_seq(6, 1, 0, 0, 2, -1);
        run_seq(0, 0, 0, 0, 3, -1);
        run_seq(6, 0, 0, 0, 3, 3);
        for (int s = 0; s < 6; s++)
            run_seq($urandom_range(1, 12), 2, 2, 1, $urandom_range(1, 6), -1);
        reset_mid_run();
        run_seq(3, 0, 2, 1, 4, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
